axi_r_resp_router: RTL and testbench
====================================

AXI_R_RESP_ROUTER -- requirements
Module: axi_r_resp_router

Interface
REQ-001 Parameter MST_NUM, default 8: number of upstream masters; the AR arbiter grant vector width.
REQ-002 Parameter DATA_W, default 32: R data width.
REQ-003 Parameter DEPTH, default 8, power of two >= 2: maximum outstanding read bursts tracked.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ar_grant  input  MST_NUM  one-hot grant of the AR round-robin arbiter.
REQ-007 ar_fire  input  1  AR handshake completed on the slave side this cycle.
REQ-008 ar_allow  output  1  high when a new AR may be issued (tracker not full).
REQ-009 s_rvalid/s_rready  input/output  1/1  slave-side R handshake.
REQ-010 s_rdata/s_rresp/s_rlast  input  DATA_W/2/1  slave-side R payload.
REQ-011 m_rvalid  output  MST_NUM  per-master R valid; at most one bit set.
REQ-012 m_rready  input  MST_NUM  per-master R ready.
REQ-013 m_rdata/m_rresp/m_rlast  output  DATA_W/2/1  R payload broadcast to all masters.
REQ-014 outstanding  output  clog2(DEPTH)+1  count of bursts tracked.
REQ-015 err_grant/err_unexp  output  1/1  sticky error flags.

Function
REQ-016 On ar_fire with a one-hot ar_grant and tracker not full, the module SHALL push the binary index of the granted master into an in-order tracker FIFO.
REQ-017 On ar_fire with ar_grant zero or multi-hot, the module SHALL drop the push and set err_grant.
REQ-018 ar_allow SHALL equal not-full; ar_fire while full SHALL be dropped and SHALL set err_grant.
REQ-019 The FIFO head index SHALL select the routing target while the FIFO is non-empty.
REQ-020 m_rvalid[head] SHALL equal s_rvalid when non-empty; all other m_rvalid bits SHALL be 0.
REQ-021 s_rready SHALL equal m_rready[head] when non-empty and 0 when empty; the path SHALL be combinational (zero latency, no payload register).
REQ-022 m_rdata, m_rresp and m_rlast SHALL pass s_rdata, s_rresp and s_rlast through unchanged.
REQ-023 A beat handshake with s_rlast=1 SHALL pop the head at the end of that cycle; the next beat routes to the new head.
REQ-024 A push and a pop in the same cycle SHALL both take effect; outstanding SHALL stay unchanged; the full state SHALL not allow a bypass push.
REQ-025 s_rvalid while empty SHALL set err_unexp; the beat SHALL remain stalled (s_rready=0).
REQ-026 FIFO pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL derive from outstanding.
REQ-027 Error flags SHALL remain set until reset.

Reset
REQ-028 While rst=1 at a clock edge: FIFO empty; outstanding=0; ar_allow=1; err_grant=0; err_unexp=0. m_rvalid and s_rready SHALL be 0 in the following cycle.
REQ-029 Reset asserted mid-burst SHALL discard all tracked bursts; no partial state SHALL survive.

Structure
REQ-030 The MST_NUM, DEPTH and IDX_W=clog2(MST_NUM) constants and the one-hot-to-index function SHALL live in the shared AXI arbiter package.
REQ-031 The tracker SHALL be a separate sub-module, sync_fifo_idx (width IDX_W, depth DEPTH, count output).

Verification
REQ-032 Grants 0x04 then 0x01, each with ar_fire; R bursts of 2 beats then 1 beat -> beats 1-2 on m_rvalid[2], beat 3 on m_rvalid[0]; outstanding goes 2,1,0.
REQ-033 Issue 8 ARs with DEPTH=8 -> ar_allow=0 and outstanding=8; a 9th ar_fire -> err_grant=1 and no push; the first rlast pop -> ar_allow=1.
REQ-034 Last beat popping and ar_fire(grant 0x80) in the same cycle -> outstanding unchanged; the next burst routes to master 7.
REQ-035 s_rvalid=1 with an empty tracker -> s_rready=0, m_rvalid=0, err_unexp=1 from the next cycle.
REQ-036 m_rready[head]=0 for 3 cycles during a burst -> s_rready=0 for those cycles; no beat lost or duplicated.
REQ-037 rst=1 mid-burst with outstanding=3 -> outstanding=0, m_rvalid=0, flags cleared after the reset edge.

Source files
------------

// File: rtl/axi_r_resp_router_pkg.sv
// Shared constants and helpers for the AXI arbiter / read-response routing slice.
// Module parameters take their defaults from here.
package axi_r_resp_router_pkg;

   localparam int MST_NUM = 8;
   localparam int DEPTH   = 8;
   localparam int IDX_W   = $clog2(MST_NUM);
   localparam int MAX_MST = 32;

   // True only when exactly one bit of the grant vector is set.
   function automatic logic is_onehot(input logic [MAX_MST-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_MST'(1))) == '0);
   endfunction

   // OR-reduction encoder; the result is meaningful only for a one-hot input.
   function automatic logic [4:0] onehot_to_idx(input logic [MAX_MST-1:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_MST; i++) begin
         if (vec[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/axi_r_resp_router_fifo.sv
// In-order tracker of granted master indices, one entry per outstanding read burst.
// Pointers wrap modulo DEPTH; full/empty come from the entry count.
module sync_fifo_idx #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_idx,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_idx,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_idx = mem_q[rd_ptr_q];

   // A push while full is refused even if a pop happens in the same cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: every combinational output gets a default on entry so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; an entry is only read after being written, gated by count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_idx;
   end

endmodule

// File: rtl/axi_r_resp_router.sv
// Routes slave R beats to the master whose AR was granted, in AR issue order.
// The R path is purely combinational; only the index tracker and error flags are registered.
module axi_r_resp_router #(
   parameter int MST_NUM = axi_r_resp_router_pkg::MST_NUM,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = axi_r_resp_router_pkg::DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [MST_NUM-1:0]        ar_grant,
   input  logic                      ar_fire,
   output logic                      ar_allow,
   input  logic                      s_rvalid,
   output logic                      s_rready,
   input  logic [DATA_W-1:0]         s_rdata,
   input  logic [1:0]                s_rresp,
   input  logic                      s_rlast,
   output logic [MST_NUM-1:0]        m_rvalid,
   input  logic [MST_NUM-1:0]        m_rready,
   output logic [DATA_W-1:0]         m_rdata,
   output logic [1:0]                m_rresp,
   output logic                      m_rlast,
   output logic [$clog2(DEPTH):0]    outstanding,
   output logic                      err_grant,
   output logic                      err_unexp
);

   import axi_r_resp_router_pkg::*;

   localparam int IDX_W = $clog2(MST_NUM);

   logic [MAX_MST-1:0] grant_ext;
   logic               grant_ok;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   head_idx;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               err_grant_q, err_grant_d;
   logic               err_unexp_q, err_unexp_d;

   always_comb begin
      grant_ext = '0;
      grant_ext[MST_NUM-1:0] = ar_grant;
   end

   assign grant_ok  = is_onehot(grant_ext);
   assign grant_idx = IDX_W'(onehot_to_idx(grant_ext));

   assign ar_allow = !fifo_full;
   assign push     = ar_fire && grant_ok && !fifo_full;
   assign pop      = s_rvalid && s_rready && s_rlast;

   sync_fifo_idx #(
      .WIDTH (IDX_W),
      .DEPTH (DEPTH)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_idx (grant_idx),
      .pop      (pop),
      .head_idx (head_idx),
      .count    (outstanding),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // With nothing tracked the beat has no owner: hold it off and leave every valid low.
   always_comb begin
      m_rvalid = '0;
      s_rready = 1'b0;
      if (!fifo_empty) begin
         m_rvalid[head_idx] = s_rvalid;
         s_rready           = m_rready[head_idx];
      end
   end

   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

   always_comb begin
      err_grant_d = err_grant_q;
      err_unexp_d = err_unexp_q;
      if (ar_fire && (!grant_ok || fifo_full)) err_grant_d = 1'b1;
      if (s_rvalid && fifo_empty)              err_unexp_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_grant_q <= 1'b0;
         err_unexp_q <= 1'b0;
      end else begin
         err_grant_q <= err_grant_d;
         err_unexp_q <= err_unexp_d;
      end
   end

   assign err_grant = err_grant_q;
   assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_axi_r_resp_router.sv
// Self-checking bench for axi_r_resp_router: directed scenarios plus a randomized run,
// all compared against a queue-based model of the burst ownership order.
module tb_axi_r_resp_router;

   localparam int MST_NUM = 8;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   typedef logic [15:0] status_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [MST_NUM-1:0] ar_grant;
   logic               ar_fire;
   logic               ar_allow;
   logic               s_rvalid;
   logic               s_rready;
   logic [DATA_W-1:0]  s_rdata;
   logic [1:0]         s_rresp;
   logic               s_rlast;
   logic [MST_NUM-1:0] m_rvalid;
   logic [MST_NUM-1:0] m_rready;
   logic [DATA_W-1:0]  m_rdata;
   logic [1:0]         m_rresp;
   logic               m_rlast;
   logic [CNT_W-1:0]   outstanding;
   logic               err_grant;
   logic               err_unexp;

   int  model_q[$];
   bit  model_eg;
   bit  model_eu;
   int  n_checks;
   int  n_fail;

   axi_r_resp_router #(
      .MST_NUM (MST_NUM),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ar_grant    (ar_grant),
      .ar_fire     (ar_fire),
      .ar_allow    (ar_allow),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_rdata     (s_rdata),
      .s_rresp     (s_rresp),
      .s_rlast     (s_rlast),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready),
      .m_rdata     (m_rdata),
      .m_rresp     (m_rresp),
      .m_rlast     (m_rlast),
      .outstanding (outstanding),
      .err_grant   (err_grant),
      .err_unexp   (err_unexp)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ones(input logic [MST_NUM-1:0] g);
      int c = 0;
      for (int i = 0; i < MST_NUM; i++) if (g[i]) c++;
      return c;
   endfunction

   function automatic int first_bit(input logic [MST_NUM-1:0] g);
      for (int i = 0; i < MST_NUM; i++) if (g[i]) return i;
      return 0;
   endfunction

   // Layout: {ar_allow, outstanding[3:0], m_rvalid[7:0], s_rready, err_grant, err_unexp}
   function automatic status_t obs_status();
      return {ar_allow, outstanding, m_rvalid, s_rready, err_grant, err_unexp};
   endfunction

   function automatic status_t exp_status();
      logic [MST_NUM-1:0] mv;
      logic               sr;
      mv = '0;
      sr = 1'b0;
      if (model_q.size() != 0) begin
         mv[model_q[0]] = s_rvalid;
         sr             = m_rready[model_q[0]];
      end
      return {model_q.size() < DEPTH, CNT_W'(model_q.size()), mv, sr, model_eg, model_eu};
   endfunction

   // Apply this cycle's inputs to the model, then advance one clock.
   task automatic step();
      bit full_now;
      bit empty_now;
      bit pop_now;
      bit push_now;
      full_now  = (model_q.size() == DEPTH);
      empty_now = (model_q.size() == 0);
      if (rst) begin
         model_q.delete();
         model_eg = 0;
         model_eu = 0;
      end else begin
         pop_now  = !empty_now && s_rvalid && s_rlast && m_rready[model_q[0]];
         push_now = ar_fire && (ones(ar_grant) == 1) && !full_now;
         if (ar_fire && !push_now) model_eg = 1;
         if (s_rvalid && empty_now) model_eu = 1;
         if (pop_now) void'(model_q.pop_front());
         if (push_now) model_q.push_back(first_bit(ar_grant));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst      = 1'b0;
      ar_grant = '0;
      ar_fire  = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rresp  = 2'b00;
      s_rlast  = 1'b0;
      m_rready = '1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs_status() !== 16'h8000) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", obs_status(), 16'h8000);
      end
   endtask

   task automatic test_basic_route();
      logic [DATA_W-1:0] d;
      do_reset();
      ar_fire = 1'b1; ar_grant = 8'h04;
      step();
      ar_grant = 8'h01;
      step();
      ar_fire = 1'b0; ar_grant = '0;
      #1;
      n_checks++;
      if (outstanding !== 4'd2) begin
         n_fail++; $display("FAIL route_outstanding_2: got %0d want 2", outstanding);
      end
      for (int b = 0; b < 3; b++) begin
         d = $urandom;
         s_rvalid = 1'b1; s_rdata = d; s_rresp = 2'(b); s_rlast = (b != 0);
         #1;
         n_checks++;
         if (m_rvalid !== ((b < 2) ? 8'h04 : 8'h01) || m_rdata !== d || m_rresp !== 2'(b)) begin
            n_fail++;
            $display("FAIL route_beat%0d: got valid=%h data=%h resp=%0d want valid=%h data=%h resp=%0d",
                     b, m_rvalid, m_rdata, m_rresp, (b < 2) ? 8'h04 : 8'h01, d, b);
         end
         step();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      n_checks++;
      if (obs_status() !== exp_status() || outstanding !== 4'd0) begin
         n_fail++; $display("FAIL route_drained: got %h want %h", obs_status(), exp_status());
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         ar_fire = 1'b1; ar_grant = 8'(1 << $urandom_range(0, MST_NUM - 1));
         step();
      end
      ar_fire = 1'b0;
      #1;
      n_checks++;
      if (ar_allow !== 1'b0 || outstanding !== 4'd8) begin
         n_fail++; $display("FAIL full_state: got allow=%b outst=%0d want allow=0 outst=8", ar_allow, outstanding);
      end
      ar_fire = 1'b1; ar_grant = 8'h10;
      step();
      ar_fire = 1'b0;
      #1;
      n_checks++;
      if (err_grant !== 1'b1 || outstanding !== 4'd8 || obs_status() !== exp_status()) begin
         n_fail++; $display("FAIL full_overflow: got %h want %h", obs_status(), exp_status());
      end
      s_rvalid = 1'b1; s_rlast = 1'b1;
      step();
      s_rvalid = 1'b0;
      #1;
      n_checks++;
      if (ar_allow !== 1'b1 || obs_status() !== exp_status()) begin
         n_fail++; $display("FAIL full_first_pop: got %h want %h", obs_status(), exp_status());
      end
      s_rvalid = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         #1;
         n_checks++;
         if (obs_status() !== exp_status()) begin
            n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, obs_status(), exp_status());
         end
         step();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
   endtask

   task automatic test_push_pop_same();
      do_reset();
      ar_fire = 1'b1; ar_grant = 8'h02;
      step();
      ar_grant = 8'h80;
      s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      n_checks++;
      if (m_rvalid !== 8'h02 || s_rready !== 1'b1) begin
         n_fail++; $display("FAIL pushpop_head: got valid=%h rdy=%b want valid=02 rdy=1", m_rvalid, s_rready);
      end
      step();
      ar_fire = 1'b0; ar_grant = '0;
      #1;
      n_checks++;
      if (outstanding !== 4'd1 || m_rvalid !== 8'h80 || obs_status() !== exp_status()) begin
         n_fail++; $display("FAIL pushpop_next: got outst=%0d valid=%h want outst=1 valid=80", outstanding, m_rvalid);
      end
      step();
      s_rvalid = 1'b0; s_rlast = 1'b0;
   endtask

   task automatic test_unexpected();
      do_reset();
      s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      n_checks++;
      if (s_rready !== 1'b0 || m_rvalid !== '0 || err_unexp !== 1'b0) begin
         n_fail++; $display("FAIL unexp_stall: got rdy=%b valid=%h err=%b want 0 00 0", s_rready, m_rvalid, err_unexp);
      end
      step();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      n_checks++;
      if (err_unexp !== 1'b1 || obs_status() !== exp_status()) begin
         n_fail++; $display("FAIL unexp_flag: got %h want %h", obs_status(), exp_status());
      end
      step();
      #1;
      n_checks++;
      if (err_unexp !== 1'b1) begin
         n_fail++; $display("FAIL unexp_sticky: got %b want 1", err_unexp);
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] d[4];
      int k;
      int cyc;
      do_reset();
      ar_fire = 1'b1; ar_grant = 8'h08;
      step();
      ar_fire = 1'b0; ar_grant = '0;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      k = 0;
      cyc = 0;
      while (k < 4 && cyc < 20) begin
         m_rready    = '1;
         m_rready[3] = !(cyc >= 1 && cyc <= 3);
         s_rvalid = 1'b1; s_rdata = d[k]; s_rlast = (k == 3);
         #1;
         n_checks++;
         if (obs_status() !== exp_status()) begin
            n_fail++; $display("FAIL bp_status_c%0d: got %h want %h", cyc, obs_status(), exp_status());
         end
         if (cyc >= 1 && cyc <= 3) begin
            n_checks++;
            if (s_rready !== 1'b0) begin
               n_fail++; $display("FAIL bp_stall_c%0d: got rdy=%b want 0", cyc, s_rready);
            end
         end
         if (s_rready === 1'b1) begin
            n_checks++;
            if (m_rdata !== d[k] || m_rvalid !== 8'h08) begin
               n_fail++; $display("FAIL bp_beat%0d: got %h/%h want %h/08", k, m_rdata, m_rvalid, d[k]);
            end
            k++;
         end
         step();
         cyc++;
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '1;
      #1;
      n_checks++;
      if (k != 4 || cyc != 7 || outstanding !== 4'd0) begin
         n_fail++; $display("FAIL bp_count: got beats=%0d cycles=%0d outst=%0d want 4 7 0", k, cyc, outstanding);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      s_rvalid = 1'b1;
      step();
      s_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ar_fire = 1'b1; ar_grant = 8'(1 << (i + 4));
         step();
      end
      ar_fire = 1'b1; ar_grant = 8'h00;
      step();
      ar_fire = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b0;
      #1;
      n_checks++;
      if (outstanding !== 4'd3 || err_grant !== 1'b1 || err_unexp !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: got outst=%0d eg=%b eu=%b want 3 1 1", outstanding, err_grant, err_unexp);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; s_rvalid = 1'b0;
      #1;
      n_checks++;
      if (obs_status() !== 16'h8000) begin
         n_fail++; $display("FAIL mid_reset: got %h want %h", obs_status(), 16'h8000);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst      = ($urandom_range(0, 127) == 0);
         ar_fire  = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 9))
            0:       ar_grant = '0;
            1:       ar_grant = 8'($urandom);
            default: ar_grant = 8'(1 << $urandom_range(0, MST_NUM - 1));
         endcase
         s_rvalid = ($urandom_range(0, 3) != 0);
         s_rdata  = $urandom;
         s_rresp  = 2'($urandom);
         s_rlast  = ($urandom_range(0, 2) == 0);
         m_rready = 8'($urandom) | 8'($urandom);
         #1;
         n_checks++;
         if (obs_status() !== exp_status() || m_rdata !== s_rdata || m_rresp !== s_rresp || m_rlast !== s_rlast) begin
            n_fail++;
            $display("FAIL rand_c%0d: got %h want %h (data %h/%h)", c, obs_status(), exp_status(), m_rdata, s_rdata);
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_eg = 0;
      model_eu = 0;
      idle_inputs();
      test_reset();
      test_basic_route();
      test_full();
      test_push_pop_same();
      test_unexpected();
      test_backpressure();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
